// File: rtl/me_stream_feeder_pkg.sv
// me_stream_feeder shared constants, state encoding and helpers.
// Block geometry defaults come from the BLK_SIZE macro when one is provided.
`ifndef BLK_SIZE
`define BLK_SIZE 8
`endif

package me_stream_feeder_pkg;

    localparam int ME_BLK_SIZE = `BLK_SIZE;
    localparam int ME_BS_SQ    = ME_BLK_SIZE * ME_BLK_SIZE;
    localparam int ME_BS_CUBE  = ME_BS_SQ * ME_BLK_SIZE;
    localparam int ME_WIN_W    = 2 * ME_BLK_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } me_state_e;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int me_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/me_addr_gen.sv
// y/x/k scan counters and the three pixel-memory address computations.
// One address triple per step; last flags the final triple of a block scan.
module me_addr_gen
    import me_stream_feeder_pkg::*;
#(
    parameter int BLK_SIZE   = 8,
    parameter int WIN_W      = 16,
    parameter int WIN_ADDR_W = 8,
    parameter int CUR_ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step,
    output logic                  last,
    output logic [CUR_ADDR_W-1:0] cur_addr,
    output logic [WIN_ADDR_W-1:0] win_addr_a,
    output logic [WIN_ADDR_W-1:0] win_addr_b
);

    localparam int CW = me_cnt_w(BLK_SIZE);
    localparam logic [CW-1:0] C_MAX = CW'(BLK_SIZE - 1);

    logic [CW-1:0] y;
    logic [CW-1:0] x;
    logic [CW-1:0] k;
    logic [WIN_ADDR_W-1:0] win_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
            x <= '0;
            k <= '0;
        end else if (clear) begin
            y <= '0;
            x <= '0;
            k <= '0;
        end else if (step) begin
            if (k == C_MAX) begin
                k <= '0;
                if (x == C_MAX) begin
                    x <= '0;
                    y <= (y == C_MAX) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign last = (k == C_MAX) && (x == C_MAX) && (y == C_MAX);

    // The window row is shared by both ports; port B sits one block to the right.
    assign win_row = (WIN_ADDR_W'(y) + WIN_ADDR_W'(x)) * WIN_ADDR_W'(WIN_W);

    assign cur_addr   = CUR_ADDR_W'(y) * CUR_ADDR_W'(BLK_SIZE) + CUR_ADDR_W'(k);
    assign win_addr_a = win_row + WIN_ADDR_W'(k);
    assign win_addr_b = win_row + WIN_ADDR_W'(k) + WIN_ADDR_W'(BLK_SIZE);

endmodule

// File: rtl/me_stream_feeder.sv
// Sequencer feeding one pe_row engine: streams c/p/p_prime from two pixel
// memories, then waits for done (or a timeout) and reports the motion vector.
module me_stream_feeder
    import me_stream_feeder_pkg::*;
#(
    parameter int BLK_SIZE   = ME_BLK_SIZE,
    parameter int WIN_W      = 2 * BLK_SIZE,
    parameter int WIN_ADDR_W = $clog2(WIN_W * WIN_W),
    parameter int CUR_ADDR_W = $clog2(BLK_SIZE * BLK_SIZE),
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    output logic                  busy,
    output logic [CUR_ADDR_W-1:0] cur_addr,
    input  logic [7:0]            cur_data,
    output logic [WIN_ADDR_W-1:0] win_addr_a,
    input  logic [7:0]            win_data_a,
    output logic [WIN_ADDR_W-1:0] win_addr_b,
    input  logic [7:0]            win_data_b,
    output logic [7:0]            p,
    output logic [7:0]            p_prime,
    output logic [7:0]            c,
    output logic                  start,
    input  logic                  pe_done,
    input  logic [7:0]            pe_mi,
    input  logic [7:0]            pe_mj,
    output logic                  res_valid,
    output logic [7:0]            res_mi,
    output logic [7:0]            res_mj,
    output logic                  res_err
);

    localparam int TW = me_cnt_w(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    me_state_e state;
    me_state_e state_nxt;

    logic            issue;
    logic            step;
    logic            clear;
    logic            last;
    logic            tail;
    logic            rd_v;
    logic            first_d1;
    logic [TW-1:0]   timer;
    logic            timed_out;

    logic [CUR_ADDR_W-1:0] ag_cur;
    logic [WIN_ADDR_W-1:0] ag_a;
    logic [WIN_ADDR_W-1:0] ag_b;

    me_addr_gen #(
        .BLK_SIZE   (BLK_SIZE),
        .WIN_W      (WIN_W),
        .WIN_ADDR_W (WIN_ADDR_W),
        .CUR_ADDR_W (CUR_ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .step       (step),
        .last       (last),
        .cur_addr   (ag_cur),
        .win_addr_a (ag_a),
        .win_addr_b (ag_b)
    );

    assign timed_out = (timer == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final STREAM cycle (tail) issues nothing; it lets the last triple drain.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        step      = 1'b0;
        clear     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (go) begin
                    clear     = 1'b1;
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                issue     = 1'b1;
                step      = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (tail) begin
                    state_nxt = ST_WAIT;
                end else begin
                    issue = 1'b1;
                    step  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (pe_done || timed_out) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail <= 1'b0;
        end else if (issue && last) begin
            tail <= 1'b1;
        end else if (state == ST_STREAM) begin
            tail <= 1'b0;
        end
    end

    // Two-stage alignment: memory read latency, then the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v     <= 1'b0;
            first_d1 <= 1'b0;
            start    <= 1'b0;
            p        <= '0;
            p_prime  <= '0;
            c        <= '0;
        end else begin
            rd_v     <= issue;
            first_d1 <= (state == ST_PRIME);
            start    <= first_d1;
            if (rd_v) begin
                p       <= win_data_a;
                p_prime <= win_data_b;
                c       <= cur_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ST_WAIT) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // A done arriving on the timeout cycle still wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_mi    <= '0;
            res_mj    <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= (state == ST_REPORT);
            if (state == ST_WAIT) begin
                if (pe_done) begin
                    res_mi  <= pe_mi;
                    res_mj  <= pe_mj;
                    res_err <= 1'b0;
                end else if (timed_out) begin
                    res_err <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign cur_addr   = issue ? ag_cur : '0;
    assign win_addr_a = issue ? ag_a : '0;
    assign win_addr_b = issue ? ag_b : '0;

endmodule

// File: tb/tb_me_stream_feeder.sv
// Self-checking bench for me_stream_feeder (BLK_SIZE=4, WIN_W=16, TIMEOUT=16).
// Table-driven runs, hand-written corner sequences and randomized runs.
module tb_me_stream_feeder;

    localparam int B  = 4;
    localparam int W  = 16;
    localparam int WA = 8;
    localparam int CA = 4;
    localparam int TO = 16;
    localparam int N3 = B * B * B;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic          busy;
    logic [CA-1:0] cur_addr;
    logic [7:0]    cur_data;
    logic [WA-1:0] win_addr_a;
    logic [7:0]    win_data_a;
    logic [WA-1:0] win_addr_b;
    logic [7:0]    win_data_b;
    logic [7:0]    p;
    logic [7:0]    p_prime;
    logic [7:0]    c;
    logic          start;
    logic          pe_done;
    logic [7:0]    pe_mi;
    logic [7:0]    pe_mj;
    logic          res_valid;
    logic [7:0]    res_mi;
    logic [7:0]    res_mj;
    logic          res_err;

    always #5 clk = ~clk;

    me_stream_feeder #(
        .BLK_SIZE   (B),
        .WIN_W      (W),
        .WIN_ADDR_W (WA),
        .CUR_ADDR_W (CA),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .busy       (busy),
        .cur_addr   (cur_addr),
        .cur_data   (cur_data),
        .win_addr_a (win_addr_a),
        .win_data_a (win_data_a),
        .win_addr_b (win_addr_b),
        .win_data_b (win_data_b),
        .p          (p),
        .p_prime    (p_prime),
        .c          (c),
        .start      (start),
        .pe_done    (pe_done),
        .pe_mi      (pe_mi),
        .pe_mj      (pe_mj),
        .res_valid  (res_valid),
        .res_mi     (res_mi),
        .res_mj     (res_mj),
        .res_err    (res_err)
    );

    logic [7:0] cmem [B*B];
    logic [7:0] wmem [W*W];

    always @(posedge clk) begin
        cur_data   <= cmem[cur_addr];
        win_data_a <= wmem[win_addr_a];
        win_data_b <= wmem[win_addr_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] eb_p  [N3];
    logic [7:0] eb_pp [N3];
    logic [7:0] eb_c  [N3];
    logic [7:0] exp_mi;
    logic [7:0] exp_mj;
    logic       exp_err;

    typedef struct {
        int         d;
        logic [7:0] mi;
        logic [7:0] mj;
        bit         go_s;
        bit         go_r;
        bit         idle_after;
        logic       e_err;
        logic [7:0] e_mi;
        logic [7:0] e_mj;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_addr_valued();
        for (int i = 0; i < B*B; i++) cmem[i] = 8'(i);
        for (int i = 0; i < W*W; i++) wmem[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < B*B; i++) cmem[i] = 8'($urandom);
        for (int i = 0; i < W*W; i++) wmem[i] = 8'($urandom);
    endtask

    // Expected beat sequence: k innermost, then x, then y.
    task automatic build_model();
        int n;
        n = 0;
        for (int y = 0; y < B; y++)
            for (int x = 0; x < B; x++)
                for (int k = 0; k < B; k++) begin
                    eb_c[n]  = cmem[y*B + k];
                    eb_p[n]  = wmem[(y+x)*W + k];
                    eb_pp[n] = wmem[(y+x)*W + k + B];
                    n++;
                end
    endtask

    // Starts a run in the current cycle and returns in the res_valid cycle.
    // d: WAIT cycle index on which pe_done is pulsed (-1 for none).
    task automatic run(input int d, input logic [7:0] mi, input logic [7:0] mj,
                       input bit go_s, input bit go_r);
        int w0;
        int rep;
        int rv;
        int bi;
        build_model();
        w0 = N3 + 2;
        if (d >= 0 && d < TO) begin
            rep = w0 + d + 1;
            exp_mi  = mi;
            exp_mj  = mj;
            exp_err = 1'b0;
        end else begin
            rep = w0 + TO;
            exp_err = 1'b1;
        end
        rv = rep + 1;
        pe_mi = mi;
        pe_mj = mj;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int cyc = 1; cyc <= rv; cyc++) begin
            pe_done = (d >= 0) && (cyc == w0 + d);
            go = (go_s && cyc == 10) || (go_r && cyc == rep);
            chk("busy", busy, cyc < rv);
            chk("start", start, cyc == 3);
            if (cyc >= 3) begin
                bi = (cyc - 3 < N3) ? cyc - 3 : N3 - 1;
                chk("p", p, eb_p[bi]);
                chk("p_prime", p_prime, eb_pp[bi]);
                chk("c", c, eb_c[bi]);
            end
            chk("res_valid", res_valid, cyc == rv);
            if (cyc == rv) begin
                chk("res_mi", res_mi, exp_mi);
                chk("res_mj", res_mj, exp_mj);
                chk("res_err", res_err, exp_err);
            end
            if (cyc < rv) tick();
        end
        pe_done = 1'b0;
        go = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_res_valid", res_valid, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{10, 8'd2,   8'd3,   0, 0, 0, 1'b0, 8'd2,   8'd3};
        tbl[1] = '{-1, 8'd9,   8'd9,   0, 0, 0, 1'b1, 8'd2,   8'd3};
        tbl[2] = '{15, 8'd5,   8'd6,   0, 0, 1, 1'b0, 8'd5,   8'd6};
        tbl[3] = '{4,  8'd7,   8'd1,   1, 1, 1, 1'b0, 8'd7,   8'd1};
        tbl[4] = '{0,  8'hAA,  8'h55,  0, 0, 1, 1'b0, 8'hAA,  8'h55};
        tbl[5] = '{16, 8'd1,   8'd1,   0, 0, 1, 1'b1, 8'hAA,  8'h55};

        reset   = 1'b1;
        go      = 1'b0;
        pe_done = 1'b0;
        pe_mi   = '0;
        pe_mj   = '0;
        exp_mi  = '0;
        exp_mj  = '0;
        exp_err = 1'b0;
        fill_addr_valued();
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_res_mi", res_mi, 8'd0);
        chk("rst_p", p, 8'd0);
        chk("rst_win_addr_b", 32'(win_addr_b), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Table runs; the first three are back-to-back with go in the res_valid cycle.
        for (int i = 0; i < 6; i++) begin
            run(tbl[i].d, tbl[i].mi, tbl[i].mj, tbl[i].go_s, tbl[i].go_r);
            chk("tbl_res_err", res_err, tbl[i].e_err);
            chk("tbl_res_mi", res_mi, tbl[i].e_mi);
            chk("tbl_res_mj", res_mj, tbl[i].e_mj);
            if (tbl[i].idle_after) idle_check(3);
        end

        // Stale pe_done in IDLE must be ignored.
        pe_mi   = 8'h11;
        pe_mj   = 8'h22;
        pe_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_res_valid", res_valid, 1'b0);
            chk("stale_res_mi", res_mi, exp_mi);
            chk("stale_res_mj", res_mj, exp_mj);
            chk("stale_res_err", res_err, exp_err);
            chk("stale_busy", busy, 1'b0);
        end
        pe_done = 1'b0;
        tick();

        // Asynchronous reset in the middle of the stream.
        build_model();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        chk("beat30_p", p, eb_p[30]);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_start", start, 1'b0);
        chk("arst_res_valid", res_valid, 1'b0);
        chk("arst_res_err", res_err, 1'b0);
        chk("arst_res_mi", res_mi, 8'd0);
        chk("arst_res_mj", res_mj, 8'd0);
        chk("arst_p", p, 8'd0);
        chk("arst_p_prime", p_prime, 8'd0);
        chk("arst_c", c, 8'd0);
        chk("arst_cur_addr", 32'(cur_addr), 32'd0);
        chk("arst_win_addr_a", 32'(win_addr_a), 32'd0);
        chk("arst_win_addr_b", 32'(win_addr_b), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_mi  = '0;
        exp_mj  = '0;
        exp_err = 1'b0;
        tick();
        run(5, 8'h3C, 8'hC3, 0, 0);
        idle_check(2);

        // Randomized runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            int d;
            fill_random();
            d = int'($urandom_range(21, 0)) - 1;
            run(d, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            if ($urandom_range(1, 0) == 1) idle_check(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
